// File: rtl/multi_ds_dac.sv
`default_nettype none
// ============================================================================
//  Module   : multi_ds_dac
//  Purpose  : Multi-channel 1-bit delta-sigma DAC. Each channel has a
//             single-entry sample buffer (pending -> active), loaded through a
//             valid/ready write port and transferred once per frame of DIV
//             clocks. A first or second order modulator turns the active
//             sample into a pulse-density bit stream.
//  Ports    : clk          - sole clock, rising edge
//             rst_n        - asynchronous active-low reset
//             s_valid      - sample write request
//             s_ready      - sample write accept (combinational)
//             s_chan       - target channel of the write
//             s_data       - unsigned sample value
//             enable       - modulator run enable
//             clr_underrun - clears all underrun flags
//             bit_out      - per-channel 1-bit modulator outputs
//             underrun     - sticky per-channel underrun flags
//  Revision : 1.0 - initial release
// ============================================================================
module multi_ds_dac #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 2,
  parameter  int ORDER    = 1,
  parameter  int DIV      = 256,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CW-1:0]       s_chan,
  input  logic [WIDTH-1:0]    s_data,
  input  logic                enable,
  input  logic                clr_underrun,
  output logic [CHANNELS-1:0] bit_out,
  output logic [CHANNELS-1:0] underrun
);

  localparam int                 c_cnt_w = $clog2(DIV);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);
  localparam logic [WIDTH-1:0]   c_full  = '1;

  logic [c_cnt_w-1:0]  r_cnt;
  logic                w_strobe;
  logic                w_wr;
  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_pend_valid;

  // Frame counter: 0..DIV-1, strobe on the last count of each frame.
  assign w_strobe = (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_strobe) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An out-of-range channel selects nothing, so it is always ready and the
  // accepted write lands nowhere.
  assign s_ready = ~|(w_sel & w_pend_valid);
  assign w_wr    = s_valid & s_ready;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [WIDTH-1:0] r_pend;
      logic [WIDTH-1:0] r_active;
      logic             r_pv;
      logic             r_ur;
      logic             w_bit;

      assign w_sel[i]        = (32'(s_chan) == 32'(i));
      assign w_pend_valid[i] = r_pv;
      assign underrun[i]     = r_ur;
      assign bit_out[i]      = w_bit;

      // A write can only be accepted while pending is empty, so a write and
      // a pending->active transfer never compete for the same register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pend   <= '0;
          r_pv     <= 1'b0;
          r_active <= '0;
          r_ur     <= 1'b0;
        end else begin
          if (w_wr && w_sel[i]) begin
            r_pend <= s_data;
          end

          if (w_wr && w_sel[i]) begin
            r_pv <= 1'b1;
          end else if (w_strobe) begin
            r_pv <= 1'b0;
          end

          if (w_strobe && r_pv) begin
            r_active <= r_pend;
          end

          // Underrun set takes priority over a coincident clear.
          if (w_strobe && !r_pv) begin
            r_ur <= 1'b1;
          end else if (clr_underrun) begin
            r_ur <= 1'b0;
          end
        end
      end

      if (ORDER == 2) begin : g_ord2
        // Sums are formed two bits wider than storage so the second
        // integrator (which adds the unsaturated first result) cannot wrap
        // before saturation.
        localparam logic signed [WIDTH+5:0] c_lim  = {4'b0000, {(WIDTH+2){1'b1}}};
        localparam logic signed [WIDTH+5:0] c_nlim = -c_lim;

        logic signed [WIDTH+3:0] r_acc1;
        logic signed [WIDTH+3:0] r_acc2;
        logic                    r_bit;
        logic signed [WIDTH+5:0] w_act;
        logic signed [WIDTH+5:0] w_fb;
        logic signed [WIDTH+5:0] w_a1n;
        logic signed [WIDTH+5:0] w_a2n;

        function automatic logic signed [WIDTH+3:0] sat(input logic signed [WIDTH+5:0] v);
          logic signed [WIDTH+5:0] t;
          if (v > c_lim) begin
            t = c_lim;
          end else if (v < c_nlim) begin
            t = c_nlim;
          end else begin
            t = v;
          end
          return t[WIDTH+3:0];
        endfunction

        assign w_act = $signed({6'b000000, r_active});
        assign w_fb  = r_bit ? $signed({6'b000000, c_full}) : '0;
        assign w_a1n = r_acc1 + w_act - w_fb;
        assign w_a2n = r_acc2 + w_a1n - w_fb;
        assign w_bit = r_bit;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_bit  <= 1'b0;
          end else if (!enable) begin
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_bit  <= 1'b0;
          end else begin
            r_acc1 <= sat(w_a1n);
            r_acc2 <= sat(w_a2n);
            r_bit  <= (w_a2n > 0);
          end
        end
      end else begin : g_ord1
        logic signed [WIDTH+1:0] r_acc1;
        logic                    r_bit;
        logic signed [WIDTH+1:0] w_act;
        logic signed [WIDTH+1:0] w_fb;
        logic signed [WIDTH+1:0] w_a1n;

        assign w_act = $signed({2'b00, r_active});
        assign w_fb  = r_bit ? $signed({2'b00, c_full}) : '0;
        assign w_a1n = r_acc1 + w_act - w_fb;
        assign w_bit = r_bit;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_acc1 <= '0;
            r_bit  <= 1'b0;
          end else if (!enable) begin
            r_acc1 <= '0;
            r_bit  <= 1'b0;
          end else begin
            r_acc1 <= w_a1n;
            r_bit  <= (w_a1n > 0);
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_ds_dac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_ds_dac
//  Purpose  : Self-checking bench for multi_ds_dac. A three-channel first
//             order instance and a one-channel second order instance run side
//             by side against a behavioural model of the sample buffering and
//             modulator arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_ds_dac;

  localparam int     W   = 16;
  localparam int     CH  = 3;
  localparam int     DIV = 16;
  localparam longint M   = (64'sd1 <<< W) - 1;
  localparam longint LIM = (64'sd1 <<< (W + 2)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    s_chan = '0;
  logic [W-1:0]  s_data = '0;
  logic          enable = 1'b0;
  logic          clr_underrun = 1'b0;
  logic [CH-1:0] bit_out;
  logic [CH-1:0] underrun;

  logic          s_valid2 = 1'b0;
  logic          s_ready2;
  logic          s_chan2 = 1'b0;
  logic [W-1:0]  s_data2 = '0;
  logic [0:0]    bit_out2;
  logic [0:0]    underrun2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_ds_dac #(.WIDTH(W), .CHANNELS(CH), .ORDER(1), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_chan(s_chan), .s_data(s_data), .enable(enable),
    .clr_underrun(clr_underrun), .bit_out(bit_out), .underrun(underrun)
  );

  multi_ds_dac #(.WIDTH(W), .CHANNELS(1), .ORDER(2), .DIV(DIV)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_chan(s_chan2), .s_data(s_data2), .enable(enable),
    .clr_underrun(clr_underrun), .bit_out(bit_out2), .underrun(underrun2)
  );

  // ---------------- behavioural model ----------------
  longint m_pend[CH], m_act[CH], m_acc[CH];
  bit     m_pv[CH], m_bit[CH], m_ur[CH];
  int     m_cnt;
  longint n_pend, n_act, n_a1, n_a2;
  bit     n_pv, n_bit, n_ur;

  function automatic logic model_ready(input int ch);
    if (ch >= CH) return 1'b1;
    return !m_pv[ch];
  endfunction

  function automatic logic [CH-1:0] m_bits();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_bit[i];
    return r;
  endfunction

  function automatic logic [CH-1:0] m_urs();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_ur[i];
    return r;
  endfunction

  function automatic longint sat(input longint v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0; m_act[i] = 0; m_acc[i] = 0;
      m_pv[i] = 0; m_bit[i] = 0; m_ur[i] = 0;
    end
    n_pend = 0; n_act = 0; n_a1 = 0; n_a2 = 0;
    n_pv = 0; n_bit = 0; n_ur = 0;
    m_cnt = 0;
  endtask

  task automatic model_tick();
    bit     strobe, wr, wr2;
    longint fb, a1, a2;
    strobe = (m_cnt == DIV - 1);
    wr     = s_valid && model_ready(int'(s_chan));
    wr2    = s_valid2 && (s_chan2 || !n_pv);
    for (int i = 0; i < CH; i++) begin
      fb = m_bit[i] ? M : 0;
      if (enable) begin
        a1 = m_acc[i] + m_act[i] - fb;
        m_acc[i] = a1;
        m_bit[i] = (a1 > 0);
      end else begin
        m_acc[i] = 0;
        m_bit[i] = 0;
      end
      if (strobe && !m_pv[i]) m_ur[i] = 1;
      else if (clr_underrun) m_ur[i] = 0;
      if (strobe && m_pv[i]) begin
        m_act[i] = m_pend[i];
        m_pv[i]  = 0;
      end
      if (wr && int'(s_chan) == i) begin
        m_pend[i] = longint'(s_data);
        m_pv[i]   = 1;
      end
    end
    fb = n_bit ? M : 0;
    if (enable) begin
      a1 = n_a1 + n_act - fb;
      a2 = n_a2 + a1 - fb;
      n_a1 = sat(a1);
      n_a2 = sat(a2);
      n_bit = (a2 > 0);
    end else begin
      n_a1 = 0; n_a2 = 0; n_bit = 0;
    end
    if (strobe && !n_pv) n_ur = 1;
    else if (clr_underrun) n_ur = 0;
    if (strobe && n_pv) begin
      n_act = n_pend;
      n_pv  = 0;
    end
    if (wr2 && !s_chan2) begin
      n_pend = longint'(s_data2);
      n_pv   = 1;
    end
    m_cnt = strobe ? 0 : m_cnt + 1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs the DUT will sample, then
  // compare all outputs mid-cycle.
  task automatic step();
    if (rst_n) model_tick();
    else model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("bit_out", 32'(bit_out), 32'(m_bits()));
    chk("underrun", 32'(underrun), 32'(m_urs()));
    chk("s_ready", 32'(s_ready), 32'(model_ready(int'(s_chan))));
    chk("bit_out2", 32'(bit_out2), 32'(n_bit));
    chk("underrun2", 32'(underrun2), 32'(n_ur));
    chk("s_ready2", 32'(s_ready2), 32'(s_chan2 || !n_pv));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int ch, input logic [W-1:0] d);
    s_valid = 1'b1;
    s_chan  = 2'(ch);
    s_data  = d;
    #1;
    chk("wr_ready", 32'(s_ready), 32'(model_ready(ch)));
    step();
    s_valid = 1'b0;
  endtask

  // Advance until the current cycle is the strobe cycle.
  task automatic to_strobe();
    for (int k = 0; k < DIV && m_cnt != DIV - 1; k++) step();
  endtask

  task automatic check_first_strobe(input string tag);
    steps(DIV - 1);
    chk({tag, "_pre"}, 32'(underrun), 0);
    step();
    chk({tag, "_at"}, 32'(underrun), 32'((1 << CH) - 1));
  endtask

  int ones, ones2, waited;

  initial begin
    model_reset();
    @(negedge clk);

    // Reset state
    chk("rst_bits", 32'(bit_out), 0);
    chk("rst_ur", 32'(underrun), 0);
    for (int c = 0; c < 4; c++) begin
      s_chan = 2'(c);
      #1;
      chk("rst_ready", 32'(s_ready), 1);
    end
    s_chan = '0;
    steps(2);

    // First strobe DIV-1 cycles after release, nothing written -> underrun
    rst_n = 1'b1;
    check_first_strobe("first_strobe");
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk("ur_cleared", 32'(underrun), 0);

    // Full-scale and zero samples
    write(0, 16'hFFFF);
    write(1, 16'h0000);
    write(2, 16'($urandom));
    s_valid2 = 1'b1; s_data2 = 16'h4000;
    step();
    s_valid2 = 1'b0;
    enable = 1'b1;
    to_strobe();
    steps(4);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("full_zero", 32'(bit_out[1:0]), 32'h1);
    end

    // Two writes to ch1 inside one frame
    write(1, 16'hFFFF);
    s_valid = 1'b1; s_chan = 2'd1; s_data = 16'h0000;
    #1;
    chk("ch1_blocked", 32'(s_ready), 0);
    waited = 0;
    while (s_ready == 1'b0 && waited < 2 * DIV) begin
      step();
      waited++;
    end
    chk("ch1_wait_bound", 32'(waited < 2 * DIV), 1);
    chk("ch1_ready_after_strobe", 32'(m_cnt), 0);
    step();
    s_valid = 1'b0;
    steps(3);
    chk("ch1_first", 32'(bit_out[1]), 1);
    to_strobe();
    steps(4);
    chk("ch1_second", 32'(bit_out[1]), 0);

    // Underrun on ch0, clear, and set-wins-over-clear
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    to_strobe();
    step();
    chk("ur0_set", 32'(underrun[0]), 1);
    steps(3);
    chk("ch0_hold", 32'(bit_out[0]), 1);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk("ur0_clr", 32'(underrun[0]), 0);
    to_strobe();
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk("ur0_set_wins", 32'(underrun[0]), 1);

    // Out-of-range channel write is accepted and discarded
    write(3, 16'h1234);
    for (int c = 0; c < CH; c++) begin
      s_chan = 2'(c);
      #1;
      chk("oob_no_effect", 32'(s_ready), 1);
    end
    s_chan = '0;

    // enable=0 clears outputs while transfers continue
    enable = 1'b0;
    step();
    chk("en0_bits", 32'(bit_out), 0);
    write(0, 16'h0000);
    to_strobe();
    step();
    chk("en0_transfer", 32'(s_ready), 1);
    enable = 1'b1;
    steps(4);
    chk("en0_new_active", 32'(bit_out[0]), 0);

    // Density: order 1 at half scale, order 2 at quarter scale
    write(0, 16'h8000);
    to_strobe();
    step();
    steps(256);
    ones = 0; ones2 = 0;
    for (int k = 0; k < 4096; k++) begin
      step();
      if (k < 1024) ones += int'(bit_out[0]);
      ones2 += int'(bit_out2[0]);
    end
    chk("density_o1", 32'(ones >= 510 && ones <= 514), 1);
    chk("density_o2", 32'(ones2 >= 983 && ones2 <= 1065), 1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      s_valid      = ($urandom_range(0, 2) == 0);
      s_chan       = 2'($urandom_range(0, 3));
      s_data       = 16'($urandom);
      s_valid2     = ($urandom_range(0, 3) == 0);
      s_data2      = 16'($urandom);
      clr_underrun = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      step();
    end
    s_valid = 1'b0; s_valid2 = 1'b0; clr_underrun = 1'b0; enable = 1'b1;

    // Mid-frame reset with pending data
    write(0, 16'hFFFF);
    to_strobe();
    steps(4);
    write(2, 16'hABCD);
    steps(3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_bits", 32'(bit_out), 0);
    chk("midrst_ur", 32'(underrun), 0);
    s_chan = 2'd2;
    #1;
    chk("midrst_ready", 32'(s_ready), 1);
    s_chan = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_first_strobe("rst_strobe");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_ds_dac.md
MULTI_DS_DAC -- requirements
Module: multi_ds_dac

Interface
REQ-001 Parameter WIDTH, default 16, is the sample width in bits; samples are unsigned.
REQ-002 Parameter CHANNELS, default 2, is the number of independent modulator channels (1..16).
REQ-003 Parameter ORDER, default 1, is the modulator order; legal values are 1 and 2.
REQ-004 Parameter DIV, default 256, is the number of clk cycles per frame (sample period), with DIV >= 2.
REQ-005 Localparam CW = max(1, clog2(CHANNELS)) SHALL size s_chan.
REQ-006 clk  input  1  sole clock; every register SHALL be clocked on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 s_valid  input  1  sample write request.
REQ-009 s_ready  output  1  sample write accept.
REQ-010 s_chan  input  CW  target channel of the write.
REQ-011 s_data  input  WIDTH  sample value.
REQ-012 enable  input  1  modulator run enable.
REQ-013 clr_underrun  input  1  clears all underrun flags.
REQ-014 bit_out  output  CHANNELS  1-bit modulator outputs; bit i belongs to channel i.
REQ-015 underrun  output  CHANNELS  sticky per-channel underrun flags.

Function
REQ-016 Each channel SHALL hold a pending register, a pending-valid flag and an active register.
REQ-017 s_ready SHALL be combinational:
- 1 when s_chan >= CHANNELS;
- otherwise the negation of the pending-valid flag of s_chan.
REQ-018 On s_valid && s_ready with s_chan < CHANNELS, the block SHALL load s_data into that channel's pending register and set its pending-valid flag.
REQ-019 On s_valid && s_ready with s_chan >= CHANNELS, the write SHALL be accepted and discarded.
REQ-020 The frame counter SHALL count 0..DIV-1 and wrap to 0; frame strobe = (counter == DIV-1).
REQ-021 On frame strobe, per channel:
- pending-valid set: copy pending to active and clear pending-valid;
- pending-valid clear: active holds and the underrun bit is set.
REQ-022 A write accepted in the strobe cycle SHALL go to pending only and SHALL NOT suppress that cycle's underrun set.
REQ-023 clr_underrun SHALL clear all underrun bits next cycle; if clr_underrun and an underrun set coincide, set wins.
REQ-024 Full-scale is M = 2^WIDTH - 1. Feedback fb = M when the channel's registered bit_out is 1, else 0.
REQ-025 ORDER=1 update:
- acc1 is a (WIDTH+2)-bit signed register;
- a1n = acc1 + active - fb;
- acc1 <= a1n; bit_out <= (a1n > 0).
REQ-026 ORDER=2 update:
- acc1 and acc2 are (WIDTH+4)-bit signed registers;
- a1n = acc1 + active - fb;
- a2n = acc2 + a1n - fb;
- both results saturate to ±(2^(WIDTH+2)-1) before storing;
- bit_out <= (a2n > 0).
REQ-027 Long-run density of ones on bit_out[i] SHALL equal active/M; active=0 SHALL give constant 0 and active=M constant 1 after settling.
REQ-028 When enable=0, all accumulators and bit_out SHALL be cleared to 0 each cycle. Handshake, frame counter, pending/active transfer and underrun SHALL keep operating.
REQ-029 Channels SHALL be fully independent; no channel's state SHALL affect another's output.

Reset
REQ-030 On rst_n low, the following SHALL clear to 0 asynchronously: pending registers, pending-valid flags, active registers, accumulators, frame counter, bit_out and underrun.
REQ-031 During and after reset, s_ready SHALL be 1 for every s_chan.
REQ-032 Reset deassertion mid-frame SHALL restart the frame counter at 0; the first strobe follows DIV-1 cycles later.

Verification
REQ-033 Assert rst_n mid-frame with pending data -> bit_out=0, underrun=0, s_ready=1 immediately; after release the first strobe occurs at cycle DIV-1.
REQ-034 WIDTH=16, ORDER=1: write ch0 0xFFFF then ch1 0x0000 -> after next strobe, bit_out[0] is 1 and bit_out[1] is 0 for every cycle after settling.
REQ-035 WIDTH=16, ORDER=1, ch0=0x8000 -> ones count in any 1024-cycle window after settling is 512±2. ORDER=2, ch0=0x4000 -> ones in 4096 cycles is 1024±41.
REQ-036 Two writes to ch1 within one frame -> second write sees s_ready=0 until the cycle after strobe; ch1 active takes the first value, the second is accepted next.
REQ-037 No write to ch0 for one frame -> underrun[0]=1 after the strobe, active value unchanged; clr_underrun pulse -> 0 next cycle; coincident set + clr -> stays 1.
REQ-038 Write with s_chan=CHANNELS -> s_ready=1, no channel state changes. enable=0 -> all bit_out 0 next cycle while strobes still transfer samples.
